// File: rtl/enc_serial_nhot_if.sv
// -----------------------------------------------------------------------------
// enc_serial_nhot_if
// Stream bundle for the serial n-hot encoder: request-vector input side,
// index output side and status flags.
//   EN        : block enable (master drives)
//   Din       : N-bit request vector, qualified by din_valid / din_ready
//   Y         : W-bit index of the currently presented set bit
//   valid     : Y is valid; accepted together with y_ready
//   y_last    : Y is the final index of the current vector
//   busy      : a vector is being scanned
//   zero_err  : one-cycle pulse after an all-zero vector was dropped
// Modports: master = source/consumer side, slave = encoder side.
// -----------------------------------------------------------------------------
interface enc_serial_nhot_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic         EN;
    logic [N-1:0] Din;
    logic         din_valid;
    logic         din_ready;
    logic [W-1:0] Y;
    logic         valid;
    logic         y_ready;
    logic         y_last;
    logic         busy;
    logic         zero_err;

    modport master (
        output EN, Din, din_valid, y_ready,
        input  din_ready, Y, valid, y_last, busy, zero_err
    );

    modport slave (
        input  EN, Din, din_valid, y_ready,
        output din_ready, Y, valid, y_last, busy, zero_err
    );
endinterface

// File: rtl/enc_serial_nhot.sv
// -----------------------------------------------------------------------------
// enc_serial_nhot
// Serial n-hot encoder: accepts an N-bit request vector with any number of
// bits set and emits the binary index of every set bit, one per cycle, over a
// valid/ready stream. LSB-first by default; define ENC_MSB_FIRST_EN to emit the
// highest set bit first instead.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : enc_serial_nhot_if slave modport (EN, Din/din_valid/din_ready,
//         Y/valid/y_ready/y_last, busy, zero_err)
// The interface instance must be built with the same N as this module.
// -----------------------------------------------------------------------------
module enc_serial_nhot #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    enc_serial_nhot_if.slave    bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic         zero_err_q, zero_err_d;

    logic [W-1:0] idx;
    logic         one_left;

    // Index of the bit presented next. The loop direction makes the last
    // matching assignment win, which selects the priority end of the vector.
    function automatic logic [W-1:0] first_idx(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = W'(i);
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = W'(i);
        end
`endif
        return r;
    endfunction

    // Exactly one bit set: clearing the lowest set bit leaves nothing.
    function automatic logic single_bit(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    assign idx      = first_idx(pending_q);
    assign one_left = single_bit(pending_q);

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        zero_err_d    = 1'b0;
        bus.din_ready = 1'b0;
        bus.valid     = 1'b0;
        bus.Y         = '0;
        bus.y_last    = 1'b0;
        bus.busy      = 1'b0;
        bus.zero_err  = zero_err_q;

        case (state_q)
            IDLE: begin
                bus.din_ready = bus.EN;
                if (bus.din_valid && bus.EN) begin
                    if (bus.Din != '0) begin
                        pending_d = bus.Din;
                        state_d   = SCAN;
                    end else begin
                        zero_err_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                bus.valid  = 1'b1;
                bus.busy   = 1'b1;
                bus.Y      = idx;
                bus.y_last = one_left;
                // Abort takes priority over a coincident output handshake.
                if (!bus.EN) begin
                    pending_d = '0;
                    state_d   = IDLE;
                end else if (bus.y_ready) begin
                    pending_d = pending_q & ~(N'(1) << idx);
                    if (one_left) state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            zero_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            zero_err_q <= zero_err_d;
        end
    end

endmodule

// File: tb/tb_enc_serial_nhot.sv
// -----------------------------------------------------------------------------
// tb_enc_serial_nhot
// Directed bench for enc_serial_nhot: an N=8 instance for the main scenarios
// and an N=5 instance for the non-power-of-two width and scan-order check.
// -----------------------------------------------------------------------------
module tb_enc_serial_nhot;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    enc_serial_nhot_if #(.N(8)) b8 ();
    enc_serial_nhot_if #(.N(5)) b5 ();

    enc_serial_nhot #(.N(8)) u8 (.clk(clk), .rst(rst), .bus(b8));
    enc_serial_nhot #(.N(5)) u5 (.clk(clk), .rst(rst), .bus(b5));

    // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b8.EN = 1'b1; b8.din_valid = 1'b0; b8.Din = '0; b8.y_ready = 1'b1;
        b5.EN = 1'b1; b5.din_valid = 1'b0; b5.Din = '0; b5.y_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        n_checks++; if (b8.valid !== 1'b0) $display("FAIL reset_valid got %b want 0", b8.valid); else n_pass++;
        n_checks++; if (b8.Y !== 3'd0) $display("FAIL reset_Y got %0d want 0", b8.Y); else n_pass++;
        n_checks++; if (b8.y_last !== 1'b0) $display("FAIL reset_y_last got %b want 0", b8.y_last); else n_pass++;
        n_checks++; if (b8.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", b8.busy); else n_pass++;
        n_checks++; if (b8.zero_err !== 1'b0) $display("FAIL reset_zero_err got %b want 0", b8.zero_err); else n_pass++;
        n_checks++; if (b8.din_ready !== 1'b1) $display("FAIL reset_din_ready got %b want 1", b8.din_ready); else n_pass++;
    endtask

    task automatic test_multi();
        logic [2:0] exp_y [3] = '{3'd2, 3'd4, 3'd7};
        b8.Din = 8'b1001_0100; b8.din_valid = 1'b1; b8.y_ready = 1'b1;
        #1;
        n_checks++; if (b8.din_ready !== 1'b1) $display("FAIL multi_ready_pre got %b want 1", b8.din_ready); else n_pass++;
        cyc();
        b8.din_valid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (b8.valid !== 1'b1) $display("FAIL multi_valid beat %0d got %b want 1", i, b8.valid); else n_pass++;
            n_checks++; if (b8.Y !== exp_y[i]) $display("FAIL multi_Y beat %0d got %0d want %0d", i, b8.Y, exp_y[i]); else n_pass++;
            n_checks++; if (b8.y_last !== (i == 2)) $display("FAIL multi_y_last beat %0d got %b want %b", i, b8.y_last, (i == 2)); else n_pass++;
            n_checks++; if (b8.din_ready !== 1'b0) $display("FAIL multi_ready_scan beat %0d got %b want 0", i, b8.din_ready); else n_pass++;
            cyc();
        end
        n_checks++; if (b8.busy !== 1'b0) $display("FAIL multi_busy_end got %b want 0", b8.busy); else n_pass++;
        n_checks++; if (b8.valid !== 1'b0) $display("FAIL multi_valid_end got %b want 0", b8.valid); else n_pass++;
        n_checks++; if (b8.din_ready !== 1'b1) $display("FAIL multi_ready_end got %b want 1", b8.din_ready); else n_pass++;
    endtask

    task automatic test_onehot();
        logic [7:0] vec   [2] = '{8'h01, 8'h80};
        logic [2:0] exp_y [2] = '{3'd0, 3'd7};
        for (int i = 0; i < 2; i++) begin
            b8.Din = vec[i]; b8.din_valid = 1'b1; b8.y_ready = 1'b1;
            cyc();
            b8.din_valid = 1'b0;
            #1;
            n_checks++; if (b8.Y !== exp_y[i]) $display("FAIL onehot_Y vec %0d got %0d want %0d", i, b8.Y, exp_y[i]); else n_pass++;
            n_checks++; if (b8.y_last !== 1'b1 || b8.valid !== 1'b1) $display("FAIL onehot_last vec %0d got last=%b valid=%b want 1,1", i, b8.y_last, b8.valid); else n_pass++;
            cyc();
            n_checks++; if (b8.valid !== 1'b0) $display("FAIL onehot_end vec %0d got valid=%b want 0", i, b8.valid); else n_pass++;
        end
    endtask

    task automatic test_stall();
        b8.Din = 8'b0110_0000; b8.din_valid = 1'b1; b8.y_ready = 1'b1;
        cyc();
        b8.din_valid = 1'b0; b8.y_ready = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (b8.Y !== 3'd5 || b8.valid !== 1'b1 || b8.y_last !== 1'b0)
                $display("FAIL stall_hold cyc %0d got Y=%0d valid=%b last=%b want 5,1,0", i, b8.Y, b8.valid, b8.y_last); else n_pass++;
            cyc();
        end
        b8.y_ready = 1'b1;
        #1;
        n_checks++; if (b8.Y !== 3'd5) $display("FAIL stall_release got Y=%0d want 5", b8.Y); else n_pass++;
        cyc();
        n_checks++; if (b8.Y !== 3'd6 || b8.y_last !== 1'b1 || b8.valid !== 1'b1)
            $display("FAIL stall_second got Y=%0d last=%b valid=%b want 6,1,1", b8.Y, b8.y_last, b8.valid); else n_pass++;
        cyc();
        n_checks++; if (b8.valid !== 1'b0) $display("FAIL stall_end got valid=%b want 0", b8.valid); else n_pass++;
    endtask

    task automatic test_zero_and_en();
        b8.Din = 8'h00; b8.din_valid = 1'b1;
        cyc();
        b8.din_valid = 1'b0;
        #1;
        n_checks++; if (b8.zero_err !== 1'b1) $display("FAIL zero_err_pulse got %b want 1", b8.zero_err); else n_pass++;
        n_checks++; if (b8.valid !== 1'b0 || b8.busy !== 1'b0) $display("FAIL zero_idle got valid=%b busy=%b want 0,0", b8.valid, b8.busy); else n_pass++;
        cyc();
        n_checks++; if (b8.zero_err !== 1'b0) $display("FAIL zero_err_width got %b want 0", b8.zero_err); else n_pass++;
        b8.EN = 1'b0; b8.Din = 8'h03; b8.din_valid = 1'b1;
        #1;
        n_checks++; if (b8.din_ready !== 1'b0) $display("FAIL en_low_ready got %b want 0", b8.din_ready); else n_pass++;
        cyc();
        n_checks++; if (b8.valid !== 1'b0 || b8.busy !== 1'b0) $display("FAIL en_low_accept got valid=%b busy=%b want 0,0", b8.valid, b8.busy); else n_pass++;
        b8.din_valid = 1'b0; b8.EN = 1'b1;
        cyc();
    endtask

    task automatic test_abort();
        b8.Din = 8'hFF; b8.din_valid = 1'b1; b8.y_ready = 1'b1;
        cyc();
        b8.din_valid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (b8.Y !== 3'(i)) $display("FAIL abort_beat %0d got Y=%0d want %0d", i, b8.Y, i); else n_pass++;
            if (i < 2) cyc();
        end
        b8.EN = 1'b0;
        #1;
        n_checks++; if (b8.y_last !== 1'b0) $display("FAIL abort_no_last got %b want 0", b8.y_last); else n_pass++;
        cyc();
        n_checks++; if (b8.valid !== 1'b0 || b8.busy !== 1'b0 || b8.y_last !== 1'b0)
            $display("FAIL abort_idle got valid=%b busy=%b last=%b want 0,0,0", b8.valid, b8.busy, b8.y_last); else n_pass++;
        b8.EN = 1'b1;
        #1;
        n_checks++; if (b8.din_ready !== 1'b1) $display("FAIL abort_ready got %b want 1", b8.din_ready); else n_pass++;
    endtask

    task automatic test_rst_mid_scan();
        b8.Din = 8'hF0; b8.din_valid = 1'b1; b8.y_ready = 1'b1;
        cyc();
        b8.din_valid = 1'b0;
        #1;
        n_checks++; if (b8.Y !== 3'd4) $display("FAIL rst_pre got Y=%0d want 4", b8.Y); else n_pass++;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        n_checks++; if (b8.valid !== 1'b0 || b8.busy !== 1'b0 || b8.Y !== 3'd0 || b8.y_last !== 1'b0)
            $display("FAIL rst_mid got valid=%b busy=%b Y=%0d last=%b want 0,0,0,0", b8.valid, b8.busy, b8.Y, b8.y_last); else n_pass++;
        cyc();
        n_checks++; if (b8.valid !== 1'b0) $display("FAIL rst_no_resume got valid=%b want 0", b8.valid); else n_pass++;
    endtask

    task automatic test_n5_order();
        logic [2:0] exp_y [3];
`ifdef ENC_MSB_FIRST_EN
        exp_y = '{3'd4, 3'd2, 3'd1};
`else
        exp_y = '{3'd1, 3'd2, 3'd4};
`endif
        b5.Din = 5'b10110; b5.din_valid = 1'b1; b5.y_ready = 1'b1;
        cyc();
        b5.din_valid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (b5.Y !== exp_y[i] || b5.valid !== 1'b1)
                $display("FAIL n5_Y beat %0d got Y=%0d valid=%b want %0d,1", i, b5.Y, b5.valid, exp_y[i]); else n_pass++;
            n_checks++; if (b5.y_last !== (i == 2)) $display("FAIL n5_last beat %0d got %b want %b", i, b5.y_last, (i == 2)); else n_pass++;
            cyc();
        end
        n_checks++; if (b5.valid !== 1'b0 || b5.busy !== 1'b0) $display("FAIL n5_end got valid=%b busy=%b want 0,0", b5.valid, b5.busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_multi();
        test_onehot();
        test_stall();
        test_zero_and_en();
        test_abort();
        test_rst_mid_scan();
        test_n5_order();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
